// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, drives the imem request/ack handshake and feeds decode
// through a one-entry skid buffer, resolving branch/jump targets with one delay slot.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        instr_valid
);

  typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

  state_e      state;
  logic [31:0] pc_if;
  logic [31:0] skid_data;
  logic [31:0] redirect_pc;
  logic        redirect_pending;

  logic        accept;
  logic        redirect_now;
  logic        enter;
  logic [31:0] pc_id_plus4;
  logic [31:0] tgt;
  logic [31:0] next_pc;

  always_comb begin
    accept       = !instr_valid || !stall;
    redirect_now = instr_valid && !stall && (jump_reg || jump_target || jump_branch);
    pc_id_plus4  = pc_id + 32'd4;
    if (jump_reg) begin
      tgt = jr_pc;
    end else if (jump_target) begin
      tgt = {pc_id_plus4[31:28], instr_id[25:0], 2'b00};
    end else begin
      tgt = pc_id_plus4 + {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
    end
    if (redirect_now) begin
      next_pc = tgt;
    end else if (redirect_pending) begin
      next_pc = redirect_pc;
    end else begin
      next_pc = pc_if + 32'd4;
    end
    // An instruction (always the delay slot after a redirect) moves into decode this cycle.
    enter = accept && ((state == StFetch && imem_ack) || state == StHold);
  end

  assign imem_req  = (state == StFetch);
  assign imem_addr = pc_if;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= StBoot;
      pc_if            <= RESET_PC;
      pc_id            <= 32'd0;
      instr_id         <= 32'd0;
      instr_valid      <= 1'b0;
      skid_data        <= 32'd0;
      redirect_pending <= 1'b0;
      redirect_pc      <= 32'd0;
    end else begin
      // Delay slot not yet fetched: park the target until it enters decode.
      if (redirect_now && !enter) begin
        redirect_pending <= 1'b1;
        redirect_pc      <= tgt;
      end else if (enter) begin
        redirect_pending <= 1'b0;
      end

      if (enter) begin
        pc_if <= next_pc;
      end

      case (state)
        StBoot: state <= StFetch;
        StFetch: begin
          if (imem_ack) begin
            if (accept) begin
              pc_id       <= pc_if;
              instr_id    <= imem_data;
              instr_valid <= 1'b1;
            end else begin
              skid_data <= imem_data;
              state     <= StHold;
            end
          end else if (accept) begin
            instr_valid <= 1'b0;
          end
        end
        StHold: begin
          if (accept) begin
            pc_id       <= pc_if;
            instr_id    <= skid_data;
            instr_valid <= 1'b1;
            state       <= StFetch;
          end
        end
        default: state <= StBoot;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: free-run, skid stall, branch/jump delay slots, reset.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump_branch;
  logic        jump_target;
  logic        jump_reg;
  logic [31:0] jr_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        instr_valid;
  logic        ack_en;

  int total = 0;
  int bad   = 0;

  instruction_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .jump_branch(jump_branch),
    .jump_target(jump_target),
    .jump_reg   (jump_reg),
    .jr_pc      (jr_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .pc_id      (pc_id),
    .instr_id   (instr_id),
    .instr_valid(instr_valid)
  );

  // Memory image: instruction word equals its address except for the two control-flow words.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h1000_FFFE;  // beq, offset -2
      32'hF000_0008: return 32'h0800_0040;  // j, index 0x40
      default:       return a;
    endcase
  endfunction

  assign imem_ack  = ack_en & imem_req;
  assign imem_data = instr_at(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0;
    jr_pc = 32'd0; ack_en = 1'b1;

    step();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc_id", pc_id, 32'h0);
    rst = 1'b0;

    // Free-run with zero-wait memory
    step();
    check("boot_req", imem_req, 1);
    check("f0_addr", imem_addr, 32'h0);
    step();
    check("f1_addr", imem_addr, 32'h4);
    check("f1_pc_id", pc_id, 32'h0);
    check("f1_valid", instr_valid, 1);
    step();
    check("f2_addr", imem_addr, 32'h8);
    check("f2_pc_id", pc_id, 32'h4);
    check("f2_instr", instr_id, 32'h4);
    step();
    check("f3_addr", imem_addr, 32'hC);
    check("f3_pc_id", pc_id, 32'h8);
    step();
    check("f4_pc_id", pc_id, 32'hC);
    check("f4_addr", imem_addr, 32'h10);
    stall = 1'b1;

    // Three stalled cycles: 0x10 lands in the skid buffer
    step();
    check("hold1_req", imem_req, 0);
    check("hold1_pc_id", pc_id, 32'hC);
    check("hold1_addr", imem_addr, 32'h10);
    step();
    check("hold2_req", imem_req, 0);
    step();
    check("hold3_req", imem_req, 0);
    check("hold3_pc_id", pc_id, 32'hC);
    stall = 1'b0;
    step();
    check("skid_pc_id", pc_id, 32'h10);
    check("skid_instr", instr_id, 32'h10);
    check("skid_addr", imem_addr, 32'h14);
    check("skid_req", imem_req, 1);
    step();
    check("post_pc_id", pc_id, 32'h14);
    check("post_instr", instr_id, 32'h14);
    check("post_addr", imem_addr, 32'h18);
    jump_reg = 1'b1; jr_pc = 32'h100;

    // JR to 0x100, slot 0x18 enters in the redirect cycle
    step();
    check("jr1_pc_id", pc_id, 32'h18);
    check("jr1_addr", imem_addr, 32'h100);
    jump_reg = 1'b0;
    step();
    check("beq_pc_id", pc_id, 32'h100);
    check("beq_instr", instr_id, 32'h1000_FFFE);
    check("beq_addr", imem_addr, 32'h104);
    jump_branch = 1'b1;

    // Taken BEQ, slot present: target 0x104 - 8
    step();
    check("beq_slot_pc", pc_id, 32'h104);
    check("beq_slot_instr", instr_id, 32'h104);
    check("beq_tgt_addr", imem_addr, 32'hFC);
    jump_branch = 1'b0;
    step();
    check("beq_tgt_pc_id", pc_id, 32'hFC);
    check("beq_tgt_next", imem_addr, 32'h100);
    step();
    check("beq2_pc_id", pc_id, 32'h100);
    check("beq2_addr", imem_addr, 32'h104);
    jump_branch = 1'b1; ack_en = 1'b0;

    // Taken BEQ, slot ack delayed four cycles: target parked
    step();
    check("late_valid", instr_valid, 0);
    check("late_addr1", imem_addr, 32'h104);
    check("late_req1", imem_req, 1);
    jump_branch = 1'b0;
    step();
    check("late_addr2", imem_addr, 32'h104);
    step();
    step();
    check("late_addr4", imem_addr, 32'h104);
    check("late_req4", imem_req, 1);
    ack_en = 1'b1;
    step();
    check("late_slot_pc", pc_id, 32'h104);
    check("late_slot_valid", instr_valid, 1);
    check("late_tgt_addr", imem_addr, 32'hFC);
    step();
    check("late_tgt_pc_id", pc_id, 32'hFC);
    check("late_tgt_next", imem_addr, 32'h100);
    jump_reg = 1'b1; jr_pc = 32'hF000_0008;

    // JR into the high segment, then J with segment bits from pc_id+4
    step();
    check("jr2_pc_id", pc_id, 32'h100);
    check("jr2_addr", imem_addr, 32'hF000_0008);
    jump_reg = 1'b0;
    step();
    check("j_pc_id", pc_id, 32'hF000_0008);
    check("j_instr", instr_id, 32'h0800_0040);
    check("j_addr", imem_addr, 32'hF000_000C);
    jump_target = 1'b1;
    step();
    check("j_slot_pc", pc_id, 32'hF000_000C);
    check("j_tgt_addr", imem_addr, 32'hF000_0100);
    jump_target = 1'b0;
    step();
    check("j_tgt_pc_id", pc_id, 32'hF000_0100);
    check("j_tgt_next", imem_addr, 32'hF000_0104);
    jump_reg = 1'b1; jr_pc = 32'h2000;
    step();
    check("jr3_slot_pc", pc_id, 32'hF000_0104);
    check("jr3_addr", imem_addr, 32'h2000);
    jump_reg = 1'b0;
    step();
    check("jr3_pc_id", pc_id, 32'h2000);
    check("jr3_next", imem_addr, 32'h2004);
    stall = 1'b1; jump_reg = 1'b1; jr_pc = 32'h3000;

    // Redirect while stalled is ignored
    step();
    check("stall_jr_req", imem_req, 0);
    check("stall_jr_pc_id", pc_id, 32'h2000);
    stall = 1'b0; jump_reg = 1'b0;
    step();
    check("stall_jr_pc2", pc_id, 32'h2004);
    check("stall_jr_addr", imem_addr, 32'h2008);
    ack_en = 1'b0; stall = 1'b1;

    // Reset while a request is outstanding
    step();
    check("pre_rst_req", imem_req, 1);
    check("pre_rst_valid", instr_valid, 1);
    check("pre_rst_addr", imem_addr, 32'h2008);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_pc_id", pc_id, 32'h0);
    step();
    rst = 1'b0; stall = 1'b0; ack_en = 1'b1;
    check("reboot_idle_req", imem_req, 0);
    step();
    check("reboot_req", imem_req, 1);
    check("reboot_addr", imem_addr, 32'h0);
    step();
    check("reboot_pc_id", pc_id, 32'h0);
    check("reboot_valid", instr_valid, 1);
    check("reboot_next", imem_addr, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
